// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron cores: register select codes,
// activation modes, FSM states and width helpers.
package perceptron_pkg;

   localparam logic [1:0] SEL_WEIGHT = 2'd0;
   localparam logic [1:0] SEL_INPUT  = 2'd1;
   localparam logic [1:0] SEL_BIAS   = 2'd2;
   localparam logic [1:0] SEL_RESULT = 2'd3;

   localparam logic MODE_STEP   = 1'b0;
   localparam logic MODE_LINEAR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_ACT  = 2'd2
   } state_e;

   function automatic int word_width(input int int_w, input int fract_w);
      return int_w + fract_w;
   endfunction

   // Sum of N full-precision products plus the shifted bias cannot overflow this.
   function automatic int acc_width(input int n, input int int_w, input int fract_w);
      return 2 * (int_w + fract_w) + $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/fp_saturate.sv
// Converts a wide accumulator (2*F fractional bits) to a W-bit Q word:
// arithmetic shift right by F, then clamp to the signed W-bit range.
module fp_saturate #(
   parameter int ACC_W = 35,
   parameter int W     = 16,
   parameter int F     = 12
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [W-1:0]     sat_o
);

   logic signed [ACC_W-1:0] shifted;
   logic [ACC_W-W:0]        hi_bits;

   assign shifted = $signed(acc_i) >>> F;
   // The value fits when every bit from W-1 upwards equals the sign.
   assign hi_bits = shifted[ACC_W-1:W-1];

   always_comb begin
      sat_o = shifted[W-1:0];
      if (!((&hi_bits) || (~|hi_bits))) begin
         if (hi_bits[ACC_W-W]) begin
            sat_o = {1'b1, {(W-1){1'b0}}};
         end else begin
            sat_o = {1'b0, {(W-1){1'b1}}};
         end
      end
   end

endmodule

// File: rtl/perceptron_mac_n.sv
// N-input fixed-point perceptron: register file, one-product-per-cycle MAC,
// and step / saturated-linear activation.
module perceptron_mac_n
   import perceptron_pkg::*;
#(
   parameter int N_INPUTS       = 4,
   parameter int FP_INT_WIDTH   = 4,
   parameter int FP_FRACT_WIDTH = 12,
   localparam int W             = word_width(FP_INT_WIDTH, FP_FRACT_WIDTH),
   localparam int AW            = $clog2(N_INPUTS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [1:0]    wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [1:0]    rd_sel,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   input  logic          start,
   input  logic          mode,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result
);

   localparam int ACC_W = acc_width(N_INPUTS, FP_INT_WIDTH, FP_FRACT_WIDTH);

   logic [W-1:0]     weight_q [N_INPUTS];
   logic [W-1:0]     in_q     [N_INPUTS];
   logic [W-1:0]     bias_q, bias_d;
   logic [W-1:0]     result_q, result_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   state_e           state_q, state_d;

   logic             wr_idle, wr_addr_ok, rd_addr_ok;
   logic [W-1:0]     w_cur, x_cur, sat_val;
   logic [2*W-1:0]   w_ext, x_ext, prod;
   logic [ACC_W-1:0] bias_ext;

   // start/wr_en are accepted only while busy is low; anything offered
   // while busy is dropped, nothing is queued.
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign result     = result_q;
   assign wr_idle    = wr_en && (state_q == ST_IDLE);
   assign wr_addr_ok = ({{(32-AW){1'b0}}, wr_addr} < 32'(N_INPUTS));
   assign rd_addr_ok = ({{(32-AW){1'b0}}, rd_addr} < 32'(N_INPUTS));

   // A bias written in the same cycle as start must seed the accumulator.
   assign bias_d   = (wr_idle && wr_sel == SEL_BIAS) ? wr_data : bias_q;
   assign bias_ext = {{(ACC_W-W){bias_d[W-1]}}, bias_d};

   assign w_cur = weight_q[idx_q];
   assign x_cur = in_q[idx_q];
   assign w_ext = {{W{w_cur[W-1]}}, w_cur};
   assign x_ext = {{W{x_cur[W-1]}}, x_cur};
   assign prod  = w_ext * x_ext;

   fp_saturate #(
      .ACC_W (ACC_W),
      .W     (W),
      .F     (FP_FRACT_WIDTH)
   ) u_sat (
      .acc_i (acc_q),
      .sat_o (sat_val)
   );

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      mode_d   = mode_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d  = mode;
               acc_d   = bias_ext << FP_FRACT_WIDTH;
               idx_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
            idx_d = idx_q + 1'b1;
            if (idx_q == AW'(N_INPUTS-1)) begin
               state_d = ST_ACT;
            end
         end
         ST_ACT: begin
            if (mode_q == MODE_LINEAR) begin
               result_d = sat_val;
            end else begin
               result_d = {{(W-1){1'b0}}, ~acc_q[ACC_W-1]};
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         idx_q    <= '0;
         mode_q   <= MODE_STEP;
         done_q   <= 1'b0;
         result_q <= {{(W-1){1'b0}}, 1'b1};
         bias_q   <= '0;
         for (int i = 0; i < N_INPUTS; i++) begin
            weight_q[i] <= '0;
            in_q[i]     <= '0;
         end
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         result_q <= result_d;
         bias_q   <= bias_d;
         if (wr_idle && wr_addr_ok && wr_sel == SEL_WEIGHT) begin
            weight_q[wr_addr] <= wr_data;
         end
         if (wr_idle && wr_addr_ok && wr_sel == SEL_INPUT) begin
            in_q[wr_addr] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_sel)
         SEL_WEIGHT: if (rd_addr_ok) rd_data = weight_q[rd_addr];
         SEL_INPUT:  if (rd_addr_ok) rd_data = in_q[rd_addr];
         SEL_BIAS:   rd_data = bias_q;
         default:    rd_data = result_q;
      endcase
   end

endmodule

// File: tb/tb_perceptron_mac_n.sv
// Bench for perceptron_mac_n with N=4, Q4.12: shadow register model feeds an
// expected-result queue that is drained each time done pulses.
module tb_perceptron_mac_n;

   localparam int N = 4;
   localparam int W = 16;
   localparam int F = 12;

   logic         clk = 1'b0;
   logic         rst, wr_en, start, mode, busy, done;
   logic [1:0]   wr_sel, rd_sel, wr_addr, rd_addr;
   logic [W-1:0] wr_data, rd_data, result;

   logic [W-1:0] sh_w [N];
   logic [W-1:0] sh_in [N];
   logic [W-1:0] sh_b;
   logic [W-1:0] exp_q [$];
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   perceptron_mac_n #(
      .N_INPUTS       (N),
      .FP_INT_WIDTH   (4),
      .FP_FRACT_WIDTH (F)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_sel  (rd_sel),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .start   (start),
      .mode    (mode),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] model(input logic m);
      longint acc, sh;
      acc = longint'($signed(sh_b)) * 4096;
      for (int i = 0; i < N; i++) begin
         acc += longint'($signed(sh_w[i])) * longint'($signed(sh_in[i]));
      end
      if (!m) return (acc >= 0) ? 16'h0001 : 16'h0000;
      sh = acc >>> F;
      if (sh > 32767) sh = 32767;
      if (sh < -32768) sh = -32768;
      return 16'(sh);
   endfunction

   task automatic clear_shadow();
      for (int i = 0; i < N; i++) begin
         sh_w[i]  = '0;
         sh_in[i] = '0;
      end
      sh_b = '0;
   endtask

   task automatic write_reg(input logic [1:0] sel, input int addr, input logic [W-1:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_addr = 2'(addr); wr_data = data;
      @(posedge clk); #1;
      wr_en = 1'b0;
      case (sel)
         2'd0: sh_w[addr]  = data;
         2'd1: sh_in[addr] = data;
         2'd2: sh_b        = data;
         default: ;
      endcase
   endtask

   task automatic load_all(input logic [W-1:0] w, input logic [W-1:0] x0, input logic [W-1:0] x1,
                           input logic [W-1:0] x2, input logic [W-1:0] x3, input logic [W-1:0] b);
      for (int i = 0; i < N; i++) write_reg(2'd0, i, w);
      write_reg(2'd1, 0, x0);
      write_reg(2'd1, 1, x1);
      write_reg(2'd1, 2, x2);
      write_reg(2'd1, 3, x3);
      write_reg(2'd2, 0, b);
   endtask

   task automatic launch(input logic m);
      @(negedge clk);
      start = 1'b1; mode = m;
      exp_q.push_back(model(m));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit seen);
      cyc = 0; seen = 1'b0;
      while (cyc < 40 && !seen) begin
         @(posedge clk); #1;
         cyc++;
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; start = 1'b0; mode = 1'b0;
      wr_sel = '0; wr_addr = '0; wr_data = '0; rd_sel = '0; rd_addr = '0;
      clear_shadow();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (result !== 16'h0001) begin n_err++; $display("FAIL reset_result: got %h want 0001", result); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge clk); rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         for (int a = 0; a < N; a++) begin
            rd_sel = 2'(s); rd_addr = 2'(a); #1;
            n_cmp++;
            if (rd_data !== 16'h0000) begin
               n_err++; $display("FAIL reset_readback sel=%0d addr=%0d: got %h want 0000", s, a, rd_data);
            end
         end
      end
      rd_sel = 2'd3; #1;
      n_cmp++; if (rd_data !== 16'h0001) begin n_err++; $display("FAIL reset_rd_result: got %h want 0001", rd_data); end
   endtask

   task automatic test_linear();
      int cyc; bit seen; logic [W-1:0] exp;
      load_all(16'h1000, 16'h1000, 16'h2000, 16'hF000, 16'h0800, 16'h0000);
      launch(1'b1);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL linear_busy: got %b want 1", busy); end
      wait_done(cyc, seen);
      n_cmp++; if (!seen || cyc != N + 1) begin n_err++; $display("FAIL linear_latency: got %0d seen=%0d want %0d", cyc, seen, N + 1); end
      exp = exp_q.pop_front();
      n_cmp++; if (result !== exp) begin n_err++; $display("FAIL linear_result: got %h want %h", result, exp); end
      n_cmp++; if (result !== 16'h2800) begin n_err++; $display("FAIL linear_2p5: got %h want 2800", result); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL linear_busy_drop: got %b want 0", busy); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL linear_done_width: got %b want 0", done); end
      rd_sel = 2'd3; #1;
      n_cmp++; if (rd_data !== 16'h2800) begin n_err++; $display("FAIL linear_rd_result: got %h want 2800", rd_data); end
   endtask

   task automatic test_step();
      int cyc; bit seen; logic [W-1:0] exp;
      write_reg(2'd2, 0, 16'hC000);
      launch(1'b0);
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || result !== exp) begin n_err++; $display("FAIL step_neg: got %h seen=%0d want %h", result, seen, exp); end
      n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL step_neg_const: got %h want 0000", result); end
      write_reg(2'd2, 0, 16'h0000);
      launch(1'b0);
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || result !== 16'h0001 || result !== exp) begin n_err++; $display("FAIL step_pos: got %h seen=%0d want %h", result, seen, exp); end
   endtask

   task automatic test_saturate();
      int cyc; bit seen; logic [W-1:0] exp;
      load_all(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000);
      launch(1'b1);
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || result !== 16'h7FFF || result !== exp) begin n_err++; $display("FAIL sat_pos: got %h seen=%0d want 7fff", result, seen); end
      for (int i = 0; i < N; i++) write_reg(2'd1, i, 16'h8000);
      launch(1'b1);
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || result !== 16'h8000 || result !== exp) begin n_err++; $display("FAIL sat_neg: got %h seen=%0d want 8000", result, seen); end
   endtask

   task automatic test_busy_ignore();
      int cyc, n_done; bit seen; logic [W-1:0] exp;
      load_all(16'h1000, 16'h1000, 16'h2000, 16'hF000, 16'h0800, 16'h0000);
      launch(1'b1);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 2'd0; wr_data = 16'h1234;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b1; mode = 1'b0;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 2'd1; wr_data = 16'h5555;
      @(negedge clk);
      wr_en = 1'b0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
      exp = exp_q.pop_front();
      n_cmp++; if (result !== exp) begin n_err++; $display("FAIL busy_result: got %h want %h", result, exp); end
      for (int a = 0; a < N; a++) begin
         rd_sel = 2'd0; rd_addr = 2'(a); #1;
         n_cmp++; if (rd_data !== sh_w[a]) begin n_err++; $display("FAIL busy_weight[%0d]: got %h want %h", a, rd_data, sh_w[a]); end
      end
      rd_sel = 2'd1; rd_addr = 2'd1; #1;
      n_cmp++; if (rd_data !== sh_in[1]) begin n_err++; $display("FAIL busy_input[1]: got %h want %h", rd_data, sh_in[1]); end
      @(negedge clk);
      wr_en = 1'b1; wr_sel = 2'd2; wr_addr = 2'd0; wr_data = 16'hC000;
      start = 1'b1; mode = 1'b0;
      sh_b = 16'hC000;
      exp_q.push_back(model(1'b0));
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0;
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || result !== exp) begin n_err++; $display("FAIL same_cycle_write: got %h seen=%0d want %h", result, seen, exp); end
   endtask

   task automatic test_random();
      int cyc; bit seen; logic [W-1:0] exp; logic m;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < N; i++) begin
            write_reg(2'd0, i, 16'($urandom_range(0, 16383)) - 16'h2000);
            write_reg(2'd1, i, (t < 3) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 8191)) - 16'h1000);
         end
         write_reg(2'd2, 0, 16'($urandom_range(0, 65535)));
         m = 1'($urandom_range(0, 1));
         launch(m);
         wait_done(cyc, seen);
         exp = exp_q.pop_front();
         n_cmp++; if (!seen || cyc != N + 1 || result !== exp) begin
            n_err++; $display("FAIL random_%0d mode=%0d: got %h cyc=%0d want %h", t, m, result, cyc, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc; bit seen; logic [W-1:0] exp;
      load_all(16'h1000, 16'h1000, 16'h2000, 16'hF000, 16'h0800, 16'h0000);
      launch(1'b1);
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || result !== exp) begin n_err++; $display("FAIL b2b_first: got %h seen=%0d want %h", result, seen, exp); end
      start = 1'b1; mode = 1'b0;
      exp_q.push_back(model(1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
      wait_done(cyc, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!seen || cyc != N + 1 || result !== exp) begin
         n_err++; $display("FAIL b2b_second: got %h cyc=%0d want %h cyc %0d", result, cyc, exp, N + 1);
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      load_all(16'h1000, 16'h1000, 16'h2000, 16'hF000, 16'h0800, 16'h0000);
      @(negedge clk);
      start = 1'b1; mode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
      n_cmp++; if (result !== 16'h0001) begin n_err++; $display("FAIL rstmid_result: got %h want 0001", result); end
      @(negedge clk); rst = 1'b0;
      clear_shadow();
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      n_cmp++; if (n_done != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
      for (int s = 0; s < 3; s++) begin
         for (int a = 0; a < N; a++) begin
            rd_sel = 2'(s); rd_addr = 2'(a); #1;
            n_cmp++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL rstmid_clear sel=%0d addr=%0d: got %h want 0000", s, a, rd_data); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_linear();
      test_step();
      test_saturate();
      test_busy_ignore();
      test_random();
      test_back_to_back();
      test_reset_mid();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/perceptron_mac_n.md
# perceptron_mac_n

Parametrised N-input fixed-point perceptron core with a sequential multiply-accumulate datapath, programmable bias and selectable activation (step or saturated linear). It replaces the fixed two-input, step-only perceptron behind the UART communication controller in `perceptron_top`. The controller writes weights, inputs and bias through a word-addressed port, pulses `start`, and reads `result` after `done`.

## Interface
- `N_INPUTS`, default 4: number of inputs/weights, at least 2.
- `FP_INT_WIDTH`, default 4: integer bits, including sign, of every Q-format word.
- `FP_FRACT_WIDTH`, default 12: fractional bits. Word width W = FP_INT_WIDTH + FP_FRACT_WIDTH.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe.
- `wr_sel` in 2: write target. 0 = weight, 1 = input, 2 = bias, 3 = reserved (write ignored).
- `wr_addr` in AW = clog2(N_INPUTS): index for weight/input writes; ignored for bias.
- `wr_data` in W: signed Q word.
- `rd_sel` in 2: readback target, same encoding as `wr_sel`; code 3 reads `result`.
- `rd_addr` in AW: readback index.
- `rd_data` out W: combinational readback of the selected register.
- `start` in 1: request an evaluation.
- `mode` in 1: activation select, sampled with `start`. 0 = step, 1 = saturated linear.
- `busy` out 1: evaluation in progress.
- `done` out 1: one-cycle pulse when `result` updates.
- `result` out W: registered activation output.

## Operation
- Storage:
  - `weight[N]`, `input[N]` and `bias` are signed W-bit registers.
  - Reset clears them all to 0.
- FSM states: IDLE, MAC, ACT.
  - IDLE: when `start` is high, latch `mode`, set acc = sign-extended bias << FP_FRACT_WIDTH, set idx = 0, assert `busy`, go to MAC.
  - MAC: acc += weight[idx] * input[idx] (full-precision signed product, 2W bits); idx++. When idx == N_INPUTS-1, go to ACT.
  - ACT: register `result`, pulse `done`, drop `busy`, go to IDLE.
- Accumulator width is 2W + clog2(N_INPUTS) + 1. Accumulation never overflows.
- Step mode: `result` = 16'd1 (integer 1, LSB set) if acc >= 0, else 0. This is the same encoding the controller already ships.
- Linear mode:
  - Take acc >> FP_FRACT_WIDTH (truncate toward -inf).
  - If it exceeds 2^(W-1)-1, clamp to 0x7FFF-equivalent; if below -2^(W-1), clamp to 0x8000-equivalent.
- Writes:
  - Accepted only in IDLE.
  - `wr_en` while `busy` is ignored silently.
  - `wr_addr` >= N_INPUTS is ignored.
- `start` while `busy` is ignored; there is no queueing.
- `wr_en` and `start` in the same IDLE cycle: the write commits at that edge and the evaluation uses the new value.
- `result` holds its value between evaluations. The controller may read `result` at any time.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `result` = 1 (step of zero weights), FSM = IDLE.
  - `rd_data` reflects the reset registers.
- Latency: `start` sampled at edge k gives MAC edges k+1..k+N and `result`/`done` updated at edge k+N+1. `done` is high for exactly that one cycle.
- `busy` is high from edge k to edge k+N+1.
- Back-to-back: `start` may be asserted in the cycle `done` is high. It is sampled in IDLE and the next evaluation begins, giving a throughput of one result per N+2 cycles.
- `rst` mid-evaluation: the next edge forces IDLE and clears all storage. `result` = 1; no `done` pulse.
- `rd_data` is combinational: zero-cycle read, no handshake.

## Structure
- Shared package `perceptron_pkg` holds:
  - the `wr_sel`/`rd_sel` codes;
  - the FSM state typedef;
  - the mode constants (MODE_STEP, MODE_LINEAR);
  - helper functions for accumulator width and W.
- One sub-module, `fp_saturate`: parametrised acc-to-W truncate-and-clamp, reused by later layers.
- MAC, index counter and register file stay in `perceptron_mac_n`. Total RTL is 150–250 lines.

## Test plan
N=4, I=4, F=12, so 1.0 = 0x1000.
1. Reset with `rst` held for 3 cycles -> `result` = 0x0001, `busy` = 0, `done` = 0, every `rd_data` read = 0x0000.
2. Weights all 0x1000, inputs 0x1000/0x2000/0xF000/0x0800, bias 0, linear mode, `start` -> `done` exactly 5 edges later, `result` = 0x2800 (2.5).
3. Same data, bias 0xC000 (-4.0), step mode -> `result` = 0x0000. Then bias 0 -> `result` = 0x0001.
4. Weights all 0x7FFF, inputs all 0x7FFF, linear -> `result` = 0x7FFF. Then inputs all 0x8000 -> `result` = 0x8000.
5. During `busy`: write weight[0] = 0x1234, pulse `start`, write addr 5 -> readback shows unchanged weights, exactly one `done`, and `result` equals the undisturbed run. Also: `wr_en` and `start` in the same IDLE cycle -> the new value is used.
6. Assert `rst` on the third MAC cycle -> next cycle `busy` = 0, no `done`, `result` = 0x0001, all registers 0.
